// File: rtl/game_pkg.sv
// Shared definitions for the 1A2B game blocks.
// Contents: scheduler state encoding, winner codes, answer geometry.
package game_pkg;

  localparam int DIGITS = 4;
  localparam int ANS_W  = 16;   // DIGITS x 4-bit BCD

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_GUESS = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_DP    = 3'd3,
    S_REPORT     = 3'd4,
    S_OVER       = 3'd5
  } sched_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter used by the free-turn build.
// The module only exists when ARB_FREE_TURN_EN is defined, so the default
// build carries no dangling top-level module.
// Ports:
//   req  [1:0] requests, bit 1 = player 1
//   last       player granted most recently
//   gnt  [1:0] one-hot grant (zero when no request)
`ifdef ARB_FREE_TURN_EN
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the player that was not served last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule
`endif

// File: rtl/guess_turn_sched.sv
// Two-player turn scheduler for 1A2B: serialises guesses onto the shared
// compare datapath, collects A/B results, counts rounds, declares the outcome.
// Config macro: ARB_FREE_TURN_EN - either player may submit, ties resolved
//   round-robin, round counter advances every second valid guess.
// Ports:
//   clka, reset(async, active low), start
//   p0/p1_req, p0/p1_guess  -> p0/p1_ack
//   dp_load, dp_ans          -> datapath;  dp_valid, dp_Anum/Bnum, dp_input_error <-
//   res_valid, res_player, res_Anum/Bnum, res_error
//   turn, turn_cnt, winner, state
module guess_turn_sched
  import game_pkg::*;
#(
  parameter int MAX_TURNS = 10,
  parameter int TC_W      = 4
) (
  input  logic             clka,
  input  logic             reset,
  input  logic             start,
  input  logic             p0_req,
  input  logic             p1_req,
  input  logic [ANS_W-1:0] p0_guess,
  input  logic [ANS_W-1:0] p1_guess,
  output logic             p0_ack,
  output logic             p1_ack,
  output logic             dp_load,
  output logic [ANS_W-1:0] dp_ans,
  input  logic             dp_valid,
  input  logic [2:0]       dp_Anum,
  input  logic [2:0]       dp_Bnum,
  input  logic             dp_input_error,
  output logic             res_valid,
  output logic             res_player,
  output logic [2:0]       res_Anum,
  output logic [2:0]       res_Bnum,
  output logic             res_error,
  output logic             turn,
  output logic [TC_W-1:0]  turn_cnt,
  output logic [1:0]       winner,
  output logic [2:0]       state
);

  sched_state_t     st, st_d;
  logic             turn_q, turn_d;
  logic [TC_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]       win_q, win_d;
  logic [ANS_W-1:0] ans_q, ans_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d, load_q, load_d, rv_q, rv_d;
  logic             rp_q, rp_d, re_q, re_d;
  logic [2:0]       ra_q, ra_d, rb_q, rb_d;
  logic             acc, acc_p;

`ifdef ARB_FREE_TURN_EN
  logic       last_q, last_d, half_q, half_d;
  logic [1:0] gnt;

  rr_arb2 u_arb (.req({p1_req, p0_req}), .last(last_q), .gnt(gnt));

  assign acc   = |gnt;
  assign acc_p = gnt[1];
`else
  // Strict alternation: only the player whose turn it is can be accepted.
  assign acc   = turn_q ? p1_req : p0_req;
  assign acc_p = turn_q;
`endif

  assign cnt_inc = cnt_q + TC_W'(1);

  always_comb begin
    st_d   = st;
    turn_d = turn_q;
    cnt_d  = cnt_q;
    win_d  = win_q;
    ans_d  = ans_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    load_d = 1'b0;
    rv_d   = 1'b0;
    rp_d   = rp_q;
    ra_d   = ra_q;
    rb_d   = rb_q;
    re_d   = re_q;
`ifdef ARB_FREE_TURN_EN
    last_d = last_q;
    half_d = half_q;
`endif
    case (st)
      S_IDLE, S_OVER: begin
        if (start) begin
          turn_d = 1'b0;
          cnt_d  = '0;
          win_d  = WIN_NONE;
          st_d   = S_WAIT_GUESS;
`ifdef ARB_FREE_TURN_EN
          last_d = 1'b1;   // p0 wins the first tie of a game
          half_d = 1'b0;
`endif
        end
      end
      S_WAIT_GUESS: begin
        if (acc) begin
          ans_d  = acc_p ? p1_guess : p0_guess;
          ack0_d = ~acc_p;
          ack1_d = acc_p;
          st_d   = S_ISSUE;
`ifdef ARB_FREE_TURN_EN
          turn_d = acc_p;
          last_d = acc_p;
`endif
        end
      end
      S_ISSUE: begin
        load_d = 1'b1;
        st_d   = S_WAIT_DP;
      end
      S_WAIT_DP: begin
        if (dp_valid) begin
          ra_d = dp_Anum;
          rb_d = dp_Bnum;
          re_d = dp_input_error;
          rp_d = turn_q;
          rv_d = 1'b1;
          st_d = S_REPORT;
        end
      end
      S_REPORT: begin
        st_d = S_WAIT_GUESS;
        if (re_q) begin
          // illegal guess: same player retries, nothing advances
        end else if (ra_q == 3'd4) begin
          win_d = turn_q ? WIN_P1 : WIN_P0;
          st_d  = S_OVER;
        end else begin
`ifdef ARB_FREE_TURN_EN
          half_d = ~half_q;
          if (half_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == TC_W'(MAX_TURNS)) begin
              win_d = WIN_DRAW;
              st_d  = S_OVER;
            end
          end
`else
          if (turn_q) cnt_d = cnt_inc;
          if (turn_q && cnt_inc == TC_W'(MAX_TURNS)) begin
            win_d = WIN_DRAW;
            st_d  = S_OVER;
          end else begin
            turn_d = ~turn_q;
          end
`endif
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      st     <= S_IDLE;
      turn_q <= 1'b0;
      cnt_q  <= '0;
      win_q  <= WIN_NONE;
      ans_q  <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      load_q <= 1'b0;
      rv_q   <= 1'b0;
      rp_q   <= 1'b0;
      ra_q   <= '0;
      rb_q   <= '0;
      re_q   <= 1'b0;
`ifdef ARB_FREE_TURN_EN
      last_q <= 1'b1;
      half_q <= 1'b0;
`endif
    end else begin
      st     <= st_d;
      turn_q <= turn_d;
      cnt_q  <= cnt_d;
      win_q  <= win_d;
      ans_q  <= ans_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      load_q <= load_d;
      rv_q   <= rv_d;
      rp_q   <= rp_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      re_q   <= re_d;
`ifdef ARB_FREE_TURN_EN
      last_q <= last_d;
      half_q <= half_d;
`endif
    end
  end

  assign p0_ack     = ack0_q;
  assign p1_ack     = ack1_q;
  assign dp_load    = load_q;
  assign dp_ans     = ans_q;
  assign res_valid  = rv_q;
  assign res_player = rp_q;
  assign res_Anum   = ra_q;
  assign res_Bnum   = rb_q;
  assign res_error  = re_q;
  assign turn       = turn_q;
  assign turn_cnt   = cnt_q;
  assign winner     = win_q;
  assign state      = st;

endmodule

// File: doc/guess_turn_sched.md
# guess_turn_sched

Two-player turn scheduler for the 1A2B game. It shares the single compare datapath between two guessing players, serialises their guess submissions, and issues each accepted guess to the datapath. It collects the A/B result, counts rounds, and declares a winner or a draw. It sits between the player input logic and the compare datapath, alongside the main game FSM.

## Interface
Parameters:
- MAX_TURNS, 10, number of rounds before a draw is declared (1..15)
- TC_W, 4, width of the round counter; must hold MAX_TURNS

Ports:
- clka  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level-sampled; begins a new game in IDLE or OVER
- p0_req / p1_req  in  1  player has a guess pending; held until acked
- p0_guess / p1_guess  in  16  four BCD digits, [15:12] is digit 0
- p0_ack / p1_ack  out  1  one-cycle pulse: guess accepted
- dp_load  out  1  one-cycle pulse: dp_ans is valid for the datapath
- dp_ans  out  16  latched guess driven to the datapath
- dp_valid  in  1  datapath result strobe
- dp_Anum / dp_Bnum  in  3  datapath result
- dp_input_error  in  1  qualified by dp_valid; guess is illegal
- res_valid  out  1  one-cycle pulse: result fields updated
- res_player  out  1  player that owns the result
- res_Anum / res_Bnum  out  3  registered copy of the datapath result
- res_error  out  1  result was an input error
- turn  out  1  player whose guess is expected next
- turn_cnt  out  TC_W  completed rounds
- winner  out  2  00 none, 01 p0, 10 p1, 11 draw
- state  out  3  FSM state encoding

## Operation
- States: IDLE=0, WAIT_GUESS=1, ISSUE=2, WAIT_DP=3, REPORT=4, OVER=5.
- IDLE: the FSM waits for start. On start: turn=0, turn_cnt=0, winner=00, go to WAIT_GUESS.
- WAIT_GUESS: the FSM samples the request of the `turn` player. If it is high, the FSM latches the guess into dp_ans, pulses that player's ack, and goes to ISSUE. The other player's req is ignored and no ack is issued.
- ISSUE: dp_load=1 for one cycle, then go to WAIT_DP.
- WAIT_DP: the FSM holds until dp_valid. It captures dp_Anum, dp_Bnum, dp_input_error and res_player=turn, then goes to REPORT. There is no timeout.
- REPORT: res_valid=1 for one cycle. Next-state decision, in priority order:
  - On an input error, turn is unchanged, turn_cnt is unchanged, and the FSM returns to WAIT_GUESS, so the same player retries.
  - If Anum==4, winner = turn+1 (01 or 10) and the FSM goes to OVER.
  - Otherwise, if turn==1, turn_cnt increments. If the new value equals MAX_TURNS, winner=11 and the FSM goes to OVER.
  - Otherwise turn toggles and the FSM returns to WAIT_GUESS.
- OVER: all outputs hold. On start, the FSM re-initialises as in IDLE.
- dp_valid outside WAIT_DP is ignored. start outside IDLE/OVER is ignored.
- A p0 win in round MAX_TURNS preempts the draw check. p1 does not get a final guess.

## Timing
- Reset values: state=IDLE, turn=0, turn_cnt=0, winner=00, all pulses 0, dp_ans=0, res_* = 0.
- Latency from req to ack is 1 cycle. The ack is registered and asserts in the cycle after req is seen in WAIT_GUESS.
- dp_load asserts exactly one cycle after the ack. dp_ans is stable from the ack cycle until the next accepted guess.
- res_valid asserts one cycle after dp_valid is sampled.
- The minimum turnaround is 5 cycles, counted from the req sample to the next WAIT_GUESS, with a datapath latency of 1.
- Reset asserted mid-game returns the block to IDLE immediately, and any in-flight datapath result is lost.

## Configuration
- ARB_FREE_TURN_EN defined:
  - Either player may submit in WAIT_GUESS; `turn` is set to the accepted player.
  - Simultaneous requests are resolved round-robin, with the player who was not last accepted winning.
  - The round counter increments after every second valid guess.
- Not defined: strict alternation as described in Operation.

## Structure
- Shared package `game_pkg`:
  - state enum `sched_state_t`
  - winner codes `WIN_NONE/WIN_P0/WIN_P1/WIN_DRAW`
  - constant `DIGITS=4`, `ANS_W=16`
- Optional sub-module `rr_arb2`: two-request round-robin arbiter. It is instantiated only under ARB_FREE_TURN_EN.

## Test plan
- Basic turn: start, then p0_req with guess 1234 and datapath A=1 B=2. Required response: p0_ack pulse, dp_load one cycle later, res_valid with player=0 A=1 B=2, then turn=1.
- Out-of-turn request: p1_req held high while turn=0. Required response: no p1_ack and no dp_load.
- Win: p1 guess with A=4. Required response: winner=10, state=OVER, and further reqs are not acked.
- Input error: p0 guess 1123 with error. Required response: res_error=1, turn stays 0, turn_cnt unchanged, p0 retry is acked.
- Draw: MAX_TURNS=2, four valid non-winning guesses. Required response: turn_cnt=2, winner=11. A following start clears winner to 00.
- Reset mid-game: drop reset during WAIT_DP. Required response: all outputs immediately at reset values, and a late dp_valid is ignored.
